// File: rtl/timer_mmio_if.sv
// CPU data-bus bundle for the timer peripheral: address, byte-masked write and registered read data.
interface timer_mmio_if;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWrite;
   logic [3:0]  byteMask;
   logic [31:0] memReadData;

   modport master (
      output memAddress, memWriteData, memWrite, byteMask,
      input  memReadData
   );

   modport slave (
      input  memAddress, memWriteData, memWrite, byteMask,
      output memReadData
   );
endinterface

// File: rtl/timer_mmio.sv
// Memory-mapped 32-bit timer/compare peripheral with prescaler, W1C match flag and level irq.
// Optional feature: define TIMER_ONESHOT_EN to add CTRL bit3 ONESHOT (self-disable on match).
module timer_mmio #(
   parameter logic [31:0] BASE_MEMORY = 32'hFFFF_FF00,
   parameter logic [31:0] TOP_MEMORY  = 32'hFFFF_FF13
) (
   input  logic        clk,
   input  logic        reset,
   timer_mmio_if.slave bus,
   output logic        irq
);

`ifdef TIMER_ONESHOT_EN
   localparam logic [3:0] CTRL_MASK = 4'hF;
`else
   localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

   logic [3:0]  ctrl_reg, ctrl_next;
   logic [15:0] prescale_reg, prescale_next;
   logic [31:0] count_reg, count_next;
   logic [31:0] compare_reg, compare_next;
   logic        match_reg, match_next;
   logic [15:0] pcnt_reg, pcnt_next;
   logic [31:0] read_data_reg, read_data_next;

   logic [31:0] offset;
   logic [2:0]  idx;
   logic        hit;
   logic        wr;
   logic [31:0] lane_mask;
   logic [31:0] rd_sel;
   logic [31:0] wr_merged;
   logic        tick;
   logic        is_match;
   logic        unused_offset_bits;

   assign hit    = (bus.memAddress >= BASE_MEMORY) && (bus.memAddress <= TOP_MEMORY);
   assign offset = bus.memAddress - BASE_MEMORY;
   assign idx    = offset[4:2];
   assign wr     = bus.memWrite && hit;
   assign unused_offset_bits = ^{offset[31:5], offset[1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_mask[8*gi +: 8] = {8{bus.byteMask[gi]}};
      end
   endgenerate

   always_comb begin
      rd_sel = 32'h0;
      case (idx)
         3'd0:    rd_sel = {28'h0, ctrl_reg};
         3'd1:    rd_sel = {16'h0, prescale_reg};
         3'd2:    rd_sel = count_reg;
         3'd3:    rd_sel = compare_reg;
         3'd4:    rd_sel = {31'h0, match_reg};
         default: rd_sel = 32'h0;
      endcase
   end

   // Byte-lane merge of the write data over the currently selected register.
   assign wr_merged = (rd_sel & ~lane_mask) | (bus.memWriteData & lane_mask);

   assign tick     = ctrl_reg[0] && (pcnt_reg == prescale_reg);
   assign is_match = tick && (count_reg == compare_reg);

   always_comb begin
      ctrl_next      = ctrl_reg;
      prescale_next  = prescale_reg;
      count_next     = count_reg;
      compare_next   = compare_reg;
      match_next     = match_reg;
      pcnt_next      = pcnt_reg;
      read_data_next = hit ? rd_sel : 32'h0;

      if (tick) begin
         count_next = (is_match && ctrl_reg[1]) ? 32'h0 : count_reg + 32'd1;
      end
`ifdef TIMER_ONESHOT_EN
      if (is_match && ctrl_reg[3]) begin
         ctrl_next[0] = 1'b0;
      end
`endif

      // CPU writes override tick-driven updates; a W1C clear loses to a same-cycle match.
      if (wr) begin
         case (idx)
            3'd0: ctrl_next     = wr_merged[3:0] & CTRL_MASK;
            3'd1: prescale_next = wr_merged[15:0];
            3'd2: count_next    = wr_merged;
            3'd3: compare_next  = wr_merged;
            3'd4: begin
               if (bus.byteMask[0] && bus.memWriteData[0]) begin
                  match_next = 1'b0;
               end
            end
            default: ;
         endcase
      end
      if (is_match) begin
         match_next = 1'b1;
      end

      if (ctrl_reg[0]) begin
         pcnt_next = tick ? 16'h0 : pcnt_reg + 16'd1;
      end
      // EN=0 always leaves pcnt at 0, so a disabled prescaler "holds" zero.
      if ((wr && idx == 3'd1) || !ctrl_next[0]) begin
         pcnt_next = 16'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_reg      <= 4'h0;
         prescale_reg  <= 16'h0;
         count_reg     <= 32'h0;
         compare_reg   <= 32'hFFFF_FFFF;
         match_reg     <= 1'b0;
         pcnt_reg      <= 16'h0;
         read_data_reg <= 32'h0;
      end else begin
         ctrl_reg      <= ctrl_next;
         prescale_reg  <= prescale_next;
         count_reg     <= count_next;
         compare_reg   <= compare_next;
         match_reg     <= match_next;
         pcnt_reg      <= pcnt_next;
         read_data_reg <= read_data_next;
      end
   end

   assign bus.memReadData = read_data_reg;
   assign irq             = match_reg & ctrl_reg[2];

endmodule

// File: tb/tb_timer_mmio.sv
// Scoreboard bench for timer_mmio: directed plan sequences then random bus traffic vs a spec-level model.
module tb_timer_mmio;
   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam logic [31:0] TOP  = 32'hFFFF_FF13;
`ifdef TIMER_ONESHOT_EN
   localparam logic [31:0] CTRL_BITS = 32'h0000_000F;
   localparam bit ONESHOT = 1'b1;
`else
   localparam logic [31:0] CTRL_BITS = 32'h0000_0007;
   localparam bit ONESHOT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic irq;
   always #5 clk = ~clk;

   timer_mmio_if bus();

   timer_mmio dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   typedef struct {
      logic [31:0] rd;
      logic        irq;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int tests = 0;
   int fails = 0;

   // Reference state: word registers 0=CTRL 1=PRESCALE 2=COUNT 3=COMPARE 4=STATUS, plus prescaler count.
   logic [31:0] m_reg [0:4];
   logic [31:0] m_pcnt;

   task automatic model_step(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                             input logic [3:0] bm, input logic rst, output exp_t e);
      logic [31:0] nxt [0:4];
      logic [31:0] n_pcnt;
      logic [31:0] wm;
      logic [31:0] merged;
      logic hit, tick, matched;
      int idx;
      e.addr = addr;
      if (rst) begin
         m_reg[0] = 0; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 32'hFFFF_FFFF; m_reg[4] = 0;
         m_pcnt = 0;
         e.rd = 0;
         e.irq = 0;
         return;
      end
      hit = (addr >= BASE) && (addr <= TOP);
      idx = hit ? int'((addr - BASE) >> 2) : 0;
      e.rd = hit ? m_reg[idx] : 32'h0;

      for (int k = 0; k < 5; k++) nxt[k] = m_reg[k];
      n_pcnt = m_pcnt;
      tick = m_reg[0][0] && (m_reg[1] == m_pcnt);
      matched = tick && (m_reg[2] == m_reg[3]);
      if (m_reg[0][0]) n_pcnt = tick ? 0 : m_pcnt + 1;
      if (tick) nxt[2] = (matched && m_reg[0][1]) ? 32'h0 : m_reg[2] + 32'd1;
      if (matched && ONESHOT && m_reg[0][3]) nxt[0][0] = 1'b0;

      if (we && hit) begin
         for (int b = 0; b < 4; b++) wm[8*b +: 8] = bm[b] ? 8'hFF : 8'h00;
         merged = (m_reg[idx] & ~wm) | (wd & wm);
         case (idx)
            0: nxt[0] = merged & CTRL_BITS;
            1: begin nxt[1] = merged & 32'h0000_FFFF; n_pcnt = 0; end
            2: nxt[2] = merged;
            3: nxt[3] = merged;
            default: if (bm[0] && wd[0]) nxt[4] = 0;
         endcase
      end
      if (matched) nxt[4] = 1;
      if (m_reg[0][0] && !nxt[0][0]) n_pcnt = 0;

      for (int k = 0; k < 5; k++) m_reg[k] = nxt[k];
      m_pcnt = n_pcnt;
      e.irq = m_reg[4][0] & m_reg[0][2];
   endtask

   task automatic cyc(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                      input logic [3:0] bm, input logic rst);
      exp_t e;
      @(negedge clk);
      reset = rst;
      bus.memAddress = addr;
      bus.memWriteData = wd;
      bus.memWrite = we;
      bus.byteMask = bm;
      model_step(addr, wd, we, bm, rst, e);
      exp_q.push_back(e);
   endtask

   task automatic rd(input int idx);
      cyc(BASE + 32'(4 * idx), $urandom, 1'b0, 4'hF, 1'b0);
   endtask

   task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] bm);
      cyc(BASE + 32'(4 * idx), d, 1'b1, bm, 1'b0);
   endtask

   task automatic do_reset();
      cyc(BASE, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1);
      cyc(BASE, 32'h0, 1'b0, 4'hF, 1'b1);
   endtask

   // Directed constant check of the read data produced by the previous bus cycle.
   task automatic expect_rd(input string name, input logic [31:0] want);
      @(posedge clk);
      #1;
      tests++;
      if (bus.memReadData !== want) begin
         fails++;
         $display("FAIL %s: memReadData=%h required %h", name, bus.memReadData, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (bus.memReadData !== e.rd) begin
               fails++;
               $display("FAIL rdata addr=%h: got %h required %h", e.addr, bus.memReadData, e.rd);
            end
            tests++;
            if (irq !== e.irq) begin
               fails++;
               $display("FAIL irq addr=%h: got %b required %b", e.addr, irq, e.irq);
            end
         end
      end
   end

   initial begin : stimulus
      logic [31:0] addr, wd;
      logic [3:0] bm;
      logic we, rst;
      int r;
      bus.memAddress = BASE;
      bus.memWriteData = 0;
      bus.memWrite = 0;
      bus.byteMask = 0;

      // Reset values read back one per cycle.
      do_reset();
      rd(0); expect_rd("reset_ctrl", 32'h0);
      rd(1); expect_rd("reset_prescale", 32'h0);
      rd(2); expect_rd("reset_count", 32'h0);
      rd(3); expect_rd("reset_compare", 32'hFFFF_FFFF);
      rd(4); expect_rd("reset_status", 32'h0);

      // Auto-reload with interrupt, prescale 0.
      wr(3, 5, 4'hF); wr(1, 0, 4'hF); wr(0, 7, 4'hF);
      for (int i = 0; i < 12; i++) rd((i % 2 == 0) ? 4 : 2);

      // Prescale 3, compare 2, no interrupt.
      do_reset();
      wr(1, 3, 4'hF); wr(3, 2, 4'hF); wr(0, 1, 4'hF);
      for (int i = 0; i < 16; i++) rd((i % 2 == 0) ? 2 : 4);

      // W1C loses to a same-cycle match; a later clear takes effect.
      do_reset();
      wr(3, 2, 4'hF); wr(0, 1, 4'hF);
      rd(2); rd(2);
      wr(4, 1, 4'h1);
      wr(4, 1, 4'h1); expect_rd("w1c_vs_match", 32'h1);
      rd(4); expect_rd("w1c_cleared", 32'h0);

      // Partial COUNT write wins over a same-cycle tick; unmapped word reads 0.
      do_reset();
      wr(0, 1, 4'hF);
      wr(2, 32'hFFFF_FFFF, 4'b0011);
      rd(2); expect_rd("count_partial", 32'h0000_FFFF);
      cyc(BASE + 32'h14, 0, 1'b0, 4'hF, 1'b0); expect_rd("unmapped", 32'h0);

      // CTRL bit3 readback and one-shot behaviour.
      do_reset();
      wr(3, 3, 4'hF); wr(0, 32'hD, 4'hF);
      for (int i = 0; i < 10; i++) rd(4);
      rd(0); expect_rd("ctrl_readback", ONESHOT ? 32'hC : 32'h5);
      if (ONESHOT) begin
         rd(2); expect_rd("oneshot_count_hold", 32'h4);
      end

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 19);
         if (r < 15)      addr = BASE + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
         else if (r < 18) addr = BASE + 32'h14 + 32'(4 * $urandom_range(0, 2));
         else if (r < 19) addr = BASE - 32'd4;
         else             addr = $urandom;
         we  = ($urandom_range(0, 2) == 0);
         wd  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
         bm  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 299) == 0);
         cyc(addr, wd, we, bm, rst);
      end

      // Drain the scoreboard with a bounded wait.
      @(negedge clk);
      bus.memWrite = 0;
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
